minute_mod_counter: RTL and testbench
=====================================

# minute_mod_counter

Parametrised modulo counter for the digital-clock datapath: the generalised successor to the fixed minute counter, usable for seconds, minutes and hours. Counts up or down on minute_clk with a run-time wrap limit, synchronous preset load and registered carry/borrow pulses that clock or enable the next stage. One instance per time digit group; carry of one instance drives the clock or enable of the next.

## Interface
Parameters:
- WIDTH, 7, count width in bits
- MAX_COUNT, 59, hard upper bound of the count (must be < 2^WIDTH)
- RESET_VALUE, 0, count value after reset (must be ≤ MAX_COUNT)

Ports:
- minute_clk  in  1  counting clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; low = hold
- up_down  in  1  1 = count up, 0 = count down
- load  in  1  synchronous preset strobe
- load_value  in  WIDTH  preset value
- limit  in  WIDTH  run-time wrap limit (last value before wrap)
- count  out  WIDTH  current count, registered
- carry  out  1  registered one-cycle pulse on up-wrap
- borrow  out  1  registered one-cycle pulse on down-wrap
- load_err  out  1  registered one-cycle pulse when a load was clamped
- at_limit  out  1  combinational, count == eff_limit

## Operation
- eff_limit = min(limit, MAX_COUNT), recomputed combinationally every cycle.
- Reset: count = RESET_VALUE; carry = borrow = load_err = 0. Takes effect immediately, independent of minute_clk.
- Priority at each rising edge: load > en > hold.
- Load (load = 1, en ignored):
  - load_value ≤ eff_limit: count ← load_value, load_err ← 0.
  - Otherwise: count ← eff_limit, load_err ← 1.
  - carry ← 0 and borrow ← 0.
- Count up (en = 1, up_down = 1):
  - count ≥ eff_limit: count ← 0, carry ← 1.
  - Otherwise: count ← count + 1, carry ← 0.
  - borrow ← 0.
- Count down (en = 1, up_down = 0):
  - count == 0: count ← eff_limit, borrow ← 1.
  - 0 < count ≤ eff_limit: count ← count − 1, borrow ← 0.
  - count > eff_limit (limit lowered at run time): count ← eff_limit, borrow ← 0.
  - carry ← 0.
- Hold (en = 0, load = 0): count unchanged; carry, borrow and load_err ← 0.
- load_err is 0 on every edge that is not a clamped load.
- limit = 0: an up count stays at 0 and pulses carry on every enabled edge; a down count stays at 0 and pulses borrow on every enabled edge.
- Arithmetic is performed at WIDTH bits. No overflow is possible because count never exceeds MAX_COUNT < 2^WIDTH.

## Timing
- All outputs except at_limit are registered and update at the same rising edge.
- Latency is 1 cycle from en/load sampled to the count change.
- carry and borrow are high for exactly one minute_clk period after the wrapping edge. Consecutive wraps (limit = 0) keep them high continuously.
- up_down changes take effect at the next enabled edge. Reversing direction does not generate a pulse.
- rst asserted mid-operation clears the pulses immediately. Counting resumes at the first rising edge after rst deasserts.
- limit and load_value must be stable around the minute_clk edge; no internal synchronisation.

## Test plan
- Reset and up count: rst pulse → count = 0, all pulses 0. Then 60 enabled up edges (limit = 59) → count 0…59,0; carry = 1 only after edge 60.
- Down wrap: load 0, up_down = 0, one enabled edge (limit = 59) → count = 59, borrow = 1 for one cycle. Next edge → 58, borrow = 0.
- Clamped load: limit = 23, load_value = 45 → count = 23, load_err = 1 for one cycle. Then load_value = 10 → count = 10, load_err = 0.
- Run-time limit change: count = 40, limit 59→23, up edge → count = 0, carry = 1. Repeat from 40 with a down edge → count = 23, borrow = 0.
- Priority and hold: load = 1 and en = 1 with load_value = 7 → count = 7. Then en = 0 for 5 edges → count stays 7, no pulses.
- Async reset mid-count: count = 30, assert rst between edges → count = 0 and carry = 0 before the next edge. Deassert rst → count advances on the following enabled edge.

Source files
------------

// File: rtl/minute_mod_counter.sv
// minute_mod_counter
// Up/down modulo counter for one digit group of the digital-clock datapath.
// The wrap point is the smaller of the run-time limit and the MAX_COUNT bound.
// A synchronous preset load is clamped to that wrap point. count, carry,
// borrow and load_err are registered. carry/borrow are single-cycle pulses
// that clock or enable the next stage. at_limit is decoded combinationally.
module minute_mod_counter #(
    parameter int WIDTH       = 7,
    parameter int MAX_COUNT   = 59,
    parameter int RESET_VALUE = 0
) (
    input  logic             minute_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             load_err,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO_W  = '0;
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] eff_limit;

    // Effective wrap point: the run-time limit can never exceed the hard bound.
    always_comb begin
        eff_limit = (limit > MAX_W) ? MAX_W : limit;
    end

    // Next-state selection with priority load > enable > hold.
    // Every pulse defaults to 0, so a pulse only lives for one edge.
    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_value <= eff_limit) begin
                count_d = load_value;
            end else begin
                count_d    = eff_limit;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_down) begin
                // A count above a freshly lowered limit also wraps to 0.
                if (count_q >= eff_limit) begin
                    count_d = ZERO_W;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + ONE_W;
                end
            end else begin
                if (count_q == ZERO_W) begin
                    count_d  = eff_limit;
                    borrow_d = 1'b1;
                end else if (count_q <= eff_limit) begin
                    count_d = count_q - ONE_W;
                end else begin
                    // The limit was lowered below the count: snap to it, no borrow.
                    count_d = eff_limit;
                end
            end
        end
    end

    // State registers. Reset is asynchronous so pulses clear without a clock.
    always_ff @(posedge minute_clk or posedge rst) begin
        if (rst) begin
            count_q    <= RESET_W;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    // Output mapping; at_limit follows the live limit input.
    always_comb begin
        count    = count_q;
        carry    = carry_q;
        borrow   = borrow_q;
        load_err = load_err_q;
        at_limit = (count_q == eff_limit);
    end

endmodule

// File: tb/tb_minute_mod_counter.sv
// Self-checking bench for minute_mod_counter (default parameters 7/59/0).
// Directed scenarios plus a randomized run against a behavioural model.
module tb_minute_mod_counter;

    logic       minute_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [6:0] load_value = '0;
    logic [6:0] limit = 7'd59;
    logic [6:0] count;
    logic       carry, borrow, load_err, at_limit;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_count = 0;
    bit m_carry = 0, m_borrow = 0, m_lerr = 0;

    always #5 minute_clk = ~minute_clk;

    minute_mod_counter #(.WIDTH(7), .MAX_COUNT(59), .RESET_VALUE(0)) dut (
        .minute_clk(minute_clk),
        .rst(rst),
        .en(en),
        .up_down(up_down),
        .load(load),
        .load_value(load_value),
        .limit(limit),
        .count(count),
        .carry(carry),
        .borrow(borrow),
        .load_err(load_err),
        .at_limit(at_limit)
    );

    function automatic int eff_of(input int lim);
        return (lim < 59) ? lim : 59;
    endfunction

    // Drive one transaction at the falling edge, advance the model by the
    // counting rules, then return at the next falling edge.
    task automatic step(input bit l, input int lv, input bit e, input bit ud, input int lim);
        int eff;
        load = l; load_value = 7'(lv); en = e; up_down = ud; limit = 7'(lim);
        eff = eff_of(lim);
        m_carry = 0; m_borrow = 0; m_lerr = 0;
        if (l) begin
            if (lv <= eff) m_count = lv;
            else begin m_count = eff; m_lerr = 1; end
        end else if (e && ud) begin
            if (m_count >= eff) begin m_count = 0; m_carry = 1; end
            else m_count = m_count + 1;
        end else if (e) begin
            if (m_count == 0) begin m_count = eff; m_borrow = 1; end
            else if (m_count > eff) m_count = eff;
            else m_count = m_count - 1;
        end
        @(posedge minute_clk);
        @(negedge minute_clk);
        $display("txn load=%0d lv=%0d en=%0d up=%0d lim=%0d -> count=%0d c=%0d b=%0d le=%0d al=%0d",
                 l, lv, e, ud, lim, count, carry, borrow, load_err, at_limit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge minute_clk);
        @(negedge minute_clk);
        m_count = 0; m_carry = 0; m_borrow = 0; m_lerr = 0;
        checks++;
        if (count !== 7'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if ({carry, borrow, load_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {carry, borrow, load_err});
        end
        checks++;
        if (at_limit !== 1'b0) begin
            errors++; $display("FAIL reset_at_limit: got %b want 0", at_limit);
        end
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, 1, 1, 59);
            checks++;
            if (count !== 7'(i % 60) || carry !== (i == 60) || borrow !== 1'b0) begin
                errors++;
                $display("FAIL up_count edge %0d: got count=%0d carry=%b borrow=%b want count=%0d carry=%b borrow=0",
                         i, count, carry, borrow, i % 60, (i == 60));
            end
            if (i == 59) begin
                checks++;
                if (at_limit !== 1'b1) begin
                    errors++; $display("FAIL up_at_limit: got %b want 1", at_limit);
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        step(1, 0, 0, 0, 59);
        step(0, 0, 1, 0, 59);
        checks++;
        if (count !== 7'd59 || borrow !== 1'b1 || carry !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap: got count=%0d borrow=%b carry=%b want 59/1/0", count, borrow, carry);
        end
        step(0, 0, 1, 0, 59);
        checks++;
        if (count !== 7'd58 || borrow !== 1'b0) begin
            errors++; $display("FAIL down_after_wrap: got count=%0d borrow=%b want 58/0", count, borrow);
        end
    endtask

    task automatic test_clamped_load();
        step(1, 45, 0, 1, 23);
        checks++;
        if (count !== 7'd23 || load_err !== 1'b1 || at_limit !== 1'b1) begin
            errors++;
            $display("FAIL clamp_load: got count=%0d load_err=%b at_limit=%b want 23/1/1", count, load_err, at_limit);
        end
        step(1, 10, 0, 1, 23);
        checks++;
        if (count !== 7'd10 || load_err !== 1'b0) begin
            errors++; $display("FAIL plain_load: got count=%0d load_err=%b want 10/0", count, load_err);
        end
        // A load above the hard bound clamps to 59 even with a larger limit.
        step(1, 100, 0, 1, 120);
        checks++;
        if (count !== 7'd59 || load_err !== 1'b1) begin
            errors++; $display("FAIL clamp_max: got count=%0d load_err=%b want 59/1", count, load_err);
        end
    endtask

    task automatic test_limit_change();
        step(1, 40, 0, 1, 59);
        step(0, 0, 1, 1, 23);
        checks++;
        if (count !== 7'd0 || carry !== 1'b1) begin
            errors++; $display("FAIL limit_drop_up: got count=%0d carry=%b want 0/1", count, carry);
        end
        step(1, 40, 0, 1, 59);
        step(0, 0, 1, 0, 23);
        checks++;
        if (count !== 7'd23 || borrow !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL limit_drop_down: got count=%0d borrow=%b carry=%b want 23/0/0", count, borrow, carry);
        end
    endtask

    task automatic test_priority_hold();
        step(1, 7, 1, 1, 59);
        checks++;
        if (count !== 7'd7) begin
            errors++; $display("FAIL load_priority: got %0d want 7", count);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 59);
            checks++;
            if (count !== 7'd7 || {carry, borrow, load_err} !== 3'b000) begin
                errors++;
                $display("FAIL hold %0d: got count=%0d pulses=%b want 7/000", i, count, {carry, borrow, load_err});
            end
        end
    endtask

    task automatic test_limit_zero();
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0);
            checks++;
            if (count !== 7'd0 || carry !== 1'b1) begin
                errors++; $display("FAIL zero_up %0d: got count=%0d carry=%b want 0/1", i, count, carry);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            checks++;
            if (count !== 7'd0 || borrow !== 1'b1 || carry !== 1'b0) begin
                errors++;
                $display("FAIL zero_down %0d: got count=%0d borrow=%b carry=%b want 0/1/0", i, count, borrow, carry);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 30, 0, 1, 59);
        #2 rst = 1'b1;
        #1;
        m_count = 0; m_carry = 0; m_borrow = 0; m_lerr = 0;
        checks++;
        if (count !== 7'd0) begin
            errors++; $display("FAIL async_reset_count: got %0d want 0", count);
        end
        @(posedge minute_clk);
        @(negedge minute_clk);
        rst = 1'b0;
        step(0, 0, 1, 1, 59);
        checks++;
        if (count !== 7'd1) begin
            errors++; $display("FAIL resume_after_reset: got %0d want 1", count);
        end
        // A live carry pulse must drop as soon as reset asserts.
        step(0, 0, 1, 1, 0);
        #2 rst = 1'b1;
        #1;
        m_count = 0; m_carry = 0; m_borrow = 0; m_lerr = 0;
        checks++;
        if (carry !== 1'b0 || count !== 7'd0) begin
            errors++; $display("FAIL async_reset_carry: got carry=%b count=%0d want 0/0", carry, count);
        end
        @(posedge minute_clk);
        @(negedge minute_clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit l, e, ud;
            int lv, lim;
            l   = ($urandom_range(0, 7) == 0);
            e   = ($urandom_range(0, 3) != 0);
            ud  = $urandom_range(0, 1) == 1;
            lv  = $urandom_range(0, 127);
            lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : 59;
            step(l, lv, e, ud, lim);
            checks++;
            if (count !== 7'(m_count) || carry !== m_carry || borrow !== m_borrow ||
                load_err !== m_lerr || at_limit !== (m_count == eff_of(lim))) begin
                errors++;
                $display("FAIL random %0d: got count=%0d c=%b b=%b le=%b al=%b want count=%0d c=%b b=%b le=%b al=%b",
                         i, count, carry, borrow, load_err, at_limit,
                         m_count, m_carry, m_borrow, m_lerr, (m_count == eff_of(lim)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_clamped_load();
        test_limit_change();
        test_priority_hold();
        test_limit_zero();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
